seven_seg_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment display driver. It samples the shared segment bus `mostrador` and the digit-select lines `digits`, waits for each digit slot to settle, and decodes the segment pattern back to a 4-bit value per digit. The block sits on the LEDS-CPLD kit clock domain and feeds the bench monitor and a second board that mirrors the countdown (DS/US) without tapping the timer directly.

---
 rtl/seven_seg_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Decodes a multiplexed 7-segment scan (shared segment bus + digit selects) back into
// one 4-bit value per digit slot, capturing each slot once its pattern has settled.
module seven_seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_50mhz,
    input  logic        init_pulse,
    input  logic [6:0]  mostrador,
    input  logic [3:0]  digits,
    output logic [15:0] digit_value_o,
    output logic [3:0]  digit_valid_o,
    output logic        update_o,
    output logic [1:0]  update_idx_o,
    output logic        pattern_err_o
);

    // state  | meaning
    // IDLE   | sample selects zero or several slots; nothing to track
    // TRACK  | one slot selected, counting consecutive identical samples
    // HELD   | current window already captured; wait for the sample to change

    localparam int unsigned       CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HELD
    } state_t;

    // Returns {decodable, value}; blank maps to 0xF so a dark digit is still reported.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h00:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [6:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       valid_q, valid_d;
    logic             update_q, update_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;

    logic             new_single;
    logic [1:0]       new_idx;
    logic             s_changed;
    logic [4:0]       dec;

    // Normalized sample: lit = 1, selected = 1.
    always_comb begin
        seg_d = SEG_ACTIVE_LOW ? ~mostrador : mostrador;
        sel_d = SEL_ACTIVE_LOW ? ~digits : digits;
    end

    always_comb begin
        new_single = 1'b0;
        new_idx    = 2'd0;
        case (sel_d)
            4'b0001: begin new_single = 1'b1; new_idx = 2'd0; end
            4'b0010: begin new_single = 1'b1; new_idx = 2'd1; end
            4'b0100: begin new_single = 1'b1; new_idx = 2'd2; end
            4'b1000: begin new_single = 1'b1; new_idx = 2'd3; end
            default: begin new_single = 1'b0; new_idx = 2'd0; end
        endcase
    end

    // The FSM judges stability on the sample being loaded this edge against the one
    // already held, so a change landing on the completing edge cancels the capture.
    assign s_changed = (seg_d != seg_q) || (sel_d != sel_q);
    assign dec       = decode_seg(seg_d);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        idx_d    = idx_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (new_single) begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TRACK, ST_HELD: begin
                if (s_changed) begin
                    if (new_single) begin
                        state_d = ST_TRACK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (state_q == ST_TRACK) begin
                    if (cnt_q >= CNT_TARGET) begin
                        state_d  = ST_HELD;
                        update_d = 1'b1;
                        idx_d    = new_idx;
                        if (dec[4]) begin
                            value_d[{new_idx, 2'b00} +: 4] = dec[3:0];
                            valid_d[new_idx]               = 1'b1;
                        end else begin
                            valid_d[new_idx] = 1'b0;
                            err_d            = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (init_pulse) begin
            seg_q    <= '0;
            sel_q    <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            value_q  <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            idx_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign digit_value_o = value_q;
    assign digit_valid_o = valid_q;
    assign update_o      = update_q;
    assign update_idx_o  = idx_q;
    assign pattern_err_o = err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: directed scan vectors push their expected capture (edge, slot,
// value, valid mask, error) and a negedge monitor checks each update_o pulse.
module tb_seven_seg_scan_decoder;

    localparam int N = 4;

    logic        clk_50mhz = 1'b0;
    logic        init_pulse;
    logic [6:0]  mostrador;
    logic [3:0]  digits;
    logic [15:0] digit_value_o;
    logic [3:0]  digit_valid_o;
    logic        update_o;
    logic [1:0]  update_idx_o;
    logic        pattern_err_o;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int          cap_edge;
        logic [1:0]  idx;
        logic        err;
        logic [15:0] value;
        logic [3:0]  valid;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_scan_decoder #(
        .STABLE_CYCLES (N),
        .SEG_ACTIVE_LOW(1'b1),
        .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_50mhz    (clk_50mhz),
        .init_pulse   (init_pulse),
        .mostrador    (mostrador),
        .digits       (digits),
        .digit_value_o(digit_value_o),
        .digit_valid_o(digit_valid_o),
        .update_o     (update_o),
        .update_idx_o (update_idx_o),
        .pattern_err_o(pattern_err_o)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (edge %0d)", name, act, exp_v, edge_cnt);
        end
    endtask

    // sel_n is the raw active-low select; seg_ah is the pattern with lit = 1.
    task automatic run_vec(input logic [3:0] sel_n, input logic [6:0] seg_ah, input int hold,
                           input bit cap, input logic [1:0] idx, input bit err,
                           input logic [15:0] value, input logic [3:0] valid);
        exp_t e;
        digits    = sel_n;
        mostrador = ~seg_ah;
        if (cap) begin
            e.cap_edge = edge_cnt + 1 + N;
            e.idx      = idx;
            e.err      = err;
            e.value    = value;
            e.valid    = valid;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk_50mhz);
    endtask

    always @(negedge clk_50mhz) begin
        exp_t e;
        if (pattern_err_o && !update_o) begin
            checks++;
            failures++;
            $display("FAIL err_without_update actual=1 expected=0 (edge %0d)", edge_cnt);
        end
        if (update_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_update actual=idx%0d value=0x%0h expected=no_update (edge %0d)",
                         update_idx_o, digit_value_o, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                chk("update_edge", edge_cnt, e.cap_edge);
                chk("update_idx", {30'd0, update_idx_o}, {30'd0, e.idx});
                chk("pattern_err", {31'd0, pattern_err_o}, {31'd0, e.err});
                chk("digit_value", {16'd0, digit_value_o}, {16'd0, e.value});
                chk("digit_valid", {28'd0, digit_valid_o}, {28'd0, e.valid});
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_value", {16'd0, digit_value_o}, 32'd0);
        chk("rst_valid", {28'd0, digit_valid_o}, 32'd0);
        chk("rst_update", {31'd0, update_o}, 32'd0);
        chk("rst_idx", {30'd0, update_idx_o}, 32'd0);
        chk("rst_err", {31'd0, pattern_err_o}, 32'd0);
    endtask

    initial begin
        init_pulse = 1'b1;
        mostrador  = 7'h7F;
        digits     = 4'hF;
        repeat (3) @(negedge clk_50mhz);
        chk_reset_outputs();
        init_pulse = 1'b0;

        //       sel      seg    hold cap idx err value     valid
        run_vec(4'b1110, 7'h5B, 100, 1, 0, 0, 16'h0002, 4'b0001);
        run_vec(4'b1110, 7'h4F, 10,  1, 0, 0, 16'h0003, 4'b0001);
        run_vec(4'b1101, 7'h3F, 10,  1, 1, 0, 16'h0003, 4'b0011);
        run_vec(4'b1011, 7'h00, 10,  1, 2, 0, 16'h0F03, 4'b0111);
        run_vec(4'b0111, 7'h6F, 10,  1, 3, 0, 16'h9F03, 4'b1111);
        run_vec(4'b1101, 7'h06, 3,   0, 0, 0, 16'h0000, 4'b0000);
        run_vec(4'b1101, 7'h07, 4,   0, 0, 0, 16'h0000, 4'b0000);
        run_vec(4'b1101, 7'h66, 10,  1, 1, 0, 16'h9F43, 4'b1111);
        run_vec(4'b1011, 7'h07, 5,   1, 2, 0, 16'h9743, 4'b1111);
        run_vec(4'b1011, 7'h49, 10,  1, 2, 1, 16'h9743, 4'b1011);
        run_vec(4'b1100, 7'h7F, 50,  0, 0, 0, 16'h0000, 4'b0000);
        run_vec(4'b1111, 7'h7F, 10,  0, 0, 0, 16'h0000, 4'b0000);
        chk("ghost_value", {16'd0, digit_value_o}, 32'h9743);
        chk("ghost_valid", {28'd0, digit_valid_o}, 32'hB);
        run_vec(4'b0111, 7'h6F, 10,  1, 3, 0, 16'h9743, 4'b1011);
        run_vec(4'b1110, 7'h5B, 10,  1, 0, 0, 16'h9742, 4'b1011);
        run_vec(4'b0111, 7'h6F, 10,  1, 3, 0, 16'h9742, 4'b1011);

        run_vec(4'b1110, 7'h6D, 2,   0, 0, 0, 16'h0000, 4'b0000);
        init_pulse = 1'b1;
        @(negedge clk_50mhz);
        chk_reset_outputs();
        init_pulse = 1'b0;
        run_vec(4'b1110, 7'h6D, 10,  1, 0, 0, 16'h0005, 4'b0001);

        repeat (5) @(negedge clk_50mhz);
        chk("pending_captures", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
